ex_div_seq: RTL and testbench

//  Sequencer for RV32M DIV/DIVU/REM/REMU, sitting beside the EX-stage ALU.

---
 rtl/ex_div_seq.sv | 167 ++++++++++++++++
 tb/tb_ex_div_seq.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_div_seq.sv
`default_nettype none
// ============================================================================
// Module      : ex_div_seq
// Description : RV32M DIV/DIVU/REM/REMU sequencer beside the EX-stage ALU.
//               Radix-2 restoring divider; holds the pipeline front while busy.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_div_seq #(
    parameter int unsigned XLEN      = 32,
    parameter bit          FAST_SPEC = 1'b1
) (
    input  logic            clk,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic            squash_i,
    input  logic            stall_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int unsigned     CNT_W    = (XLEN > 1) ? $clog2(XLEN) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   dvd_q, dvd_d;     // dividend shifts out, quotient shifts in
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   dsr_q, dsr_d;
    logic              is_rem_q, is_rem_d;
    logic              neg_quo_q, neg_quo_d;
    logic              neg_rem_q, neg_rem_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              w_signed, w_sign1, w_sign2, w_div_zero, w_overflow, w_accept;
    logic [XLEN-1:0]   w_abs1, w_abs2, w_spec_res, w_quo, w_rmd;
    logic [XLEN:0]     w_rem_sh, w_rem_sub;
    logic              w_ge;

    always_comb begin
        w_signed   = ~op_i[0];
        w_sign1    = w_signed & op1_i[XLEN-1];
        w_sign2    = w_signed & op2_i[XLEN-1];
        w_abs1     = w_sign1 ? (~op1_i + XLEN'(1)) : op1_i;
        w_abs2     = w_sign2 ? (~op2_i + XLEN'(1)) : op2_i;
        w_div_zero = (op2_i == '0);
        w_overflow = w_signed & (op1_i == MIN_NEG) & (op2_i == '1);
        w_accept   = start_i & ~squash_i;

        if (w_div_zero) begin
            w_spec_res = op_i[1] ? op1_i : '1;
        end else begin
            w_spec_res = op_i[1] ? '0 : MIN_NEG;
        end

        // One restoring step on an XLEN+1 bit partial remainder.
        w_rem_sh  = {rem_q, dvd_q[XLEN-1]};
        w_ge      = (w_rem_sh >= {1'b0, dsr_q});
        w_rem_sub = w_rem_sh - {1'b0, dsr_q};

        w_quo = neg_quo_q ? (~dvd_q + XLEN'(1)) : dvd_q;
        w_rmd = neg_rem_q ? (~rem_q + XLEN'(1)) : rem_q;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dvd_d     = dvd_q;
        rem_d     = rem_q;
        dsr_d     = dsr_q;
        is_rem_d  = is_rem_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        stall_o   = 1'b0;
        done_o    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    stall_o   = 1'b1;
                    is_rem_d  = op_i[1];
                    dvd_d     = w_abs1;
                    dsr_d     = w_abs2;
                    rem_d     = '0;
                    cnt_d     = CNT_INIT;
                    // A zero divisor yields all-ones quotient regardless of dividend sign.
                    neg_quo_d = (w_sign1 ^ w_sign2) & ~w_div_zero;
                    neg_rem_d = w_sign1;
                    if (FAST_SPEC && (w_div_zero || w_overflow)) begin
                        result_d = w_spec_res;
                        state_d  = S_DONE;
                    end else begin
                        state_d  = S_CALC;
                    end
                end
            end
            S_CALC: begin
                stall_o = 1'b1;
                rem_d   = w_ge ? w_rem_sub[XLEN-1:0] : w_rem_sh[XLEN-1:0];
                dvd_d   = {dvd_q[XLEN-2:0], w_ge};
                if (squash_i) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_FIX: begin
                stall_o = 1'b1;
                if (squash_i) begin
                    state_d = S_IDLE;
                end else begin
                    result_d = is_rem_q ? w_rmd : w_quo;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                done_o = 1'b1;
                if (!stall_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            dvd_q     <= '0;
            rem_q     <= '0;
            dsr_q     <= '0;
            is_rem_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dvd_q     <= dvd_d;
            rem_q     <= rem_d;
            dsr_q     <= dsr_d;
            is_rem_q  <= is_rem_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
        end
    end

    assign result_o = result_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_div_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_div_seq
// Description : Scoreboard bench for ex_div_seq against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_div_seq;

    localparam logic [31:0] MIN_NEG = 32'h8000_0000;
    localparam int          NORM_LAT = 34;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        start_i = 1'b0, squash_i = 1'b0, stall_i = 1'b0;
    logic [1:0]  op_i = 2'b00;
    logic [31:0] op1_i = '0, op2_i = '0;
    logic        stall_o, done_o;
    logic [31:0] result_o;

    int checks = 0;
    int failures = 0;

    logic [31:0] exp_q[$];
    logic [31:0] cur_exp = '0;
    logic        cur_valid = 1'b0;
    logic        prev_done = 1'b0;

    ex_div_seq #(.XLEN(32), .FAST_SPEC(1'b1)) dut (
        .clk      (clk),
        .rst_ni   (rst_ni),
        .start_i  (start_i),
        .squash_i (squash_i),
        .stall_i  (stall_i),
        .op_i     (op_i),
        .op1_i    (op1_i),
        .op2_i    (op2_i),
        .stall_o  (stall_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == MIN_NEG && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : MIN_NEG;
        case (op)
            2'b00:   return sa / sb;
            2'b01:   return a / b;
            2'b10:   return sa % sb;
            default: return a % b;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: pops one expected value per done_o pulse, checks every done cycle.
    always @(negedge clk) begin
        if (!rst_ni) begin
            prev_done = 1'b0;
            cur_valid = 1'b0;
        end else begin
            if (done_o) begin
                if (!prev_done) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        cur_valid = 1'b0;
                        $display("FAIL unexpected_done: got result %h expected no done", result_o);
                    end else begin
                        cur_exp   = exp_q.pop_front();
                        cur_valid = 1'b1;
                    end
                end
                if (cur_valid) check("result", result_o, cur_exp);
            end
            prev_done = done_o;
        end
    end

    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
        int lat, cyc, stalls, k;
        logic special;
        special = (b == 32'd0) || (!op[0] && a == MIN_NEG && b == 32'hFFFF_FFFF);
        lat = special ? 1 : NORM_LAT;
        exp_q.push_back(ref_result(op, a, b));
        @(negedge clk);
        start_i = 1'b1;
        op_i    = op;
        op1_i   = a;
        op2_i   = b;
        stalls  = 0;
        #1;
        for (cyc = 0; cyc < 100 && !done_o; cyc++) begin
            if (stall_o) stalls++;
            @(negedge clk);
            op1_i = $urandom;
            op2_i = $urandom;
            #1;
        end
        if (!done_o) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: got no done in %0d cycles expected done at %0d", cyc, lat);
            void'(exp_q.pop_back());
            start_i = 1'b0;
            return;
        end
        check("latency", cyc, lat);
        check("stall_cycles", stalls, lat);
        check("stall_in_done", {31'd0, stall_o}, 32'd0);
        for (k = 0; done_o && k < 20; k++) begin
            stall_i = (k < hold);
            @(negedge clk);
            #1;
        end
        stall_i = 1'b0;
        check("done_cycles", k, hold + 1);
        start_i = 1'b0;
        #1;
        check("no_restart", {30'd0, stall_o, done_o}, 32'd0);
    endtask

    initial begin
        logic [31:0] a, b;
        logic [1:0]  op;
        logic        seen_done;

        #12;
        check("rst_stall", {31'd0, stall_o}, 32'd0);
        check("rst_done", {31'd0, done_o}, 32'd0);
        check("rst_result", result_o, 32'd0);
        @(negedge clk);
        rst_ni = 1'b1;

        do_op(2'b01, 32'd100, 32'd7, 0);
        do_op(2'b11, 32'd100, 32'd7, 0);
        do_op(2'b00, -32'sd7, 32'd2, 0);
        do_op(2'b10, -32'sd7, 32'd2, 0);
        do_op(2'b10, 32'd7, -32'sd2, 0);
        do_op(2'b00, 32'd5, 32'd0, 0);
        do_op(2'b11, 32'd5, 32'd0, 0);
        do_op(2'b00, MIN_NEG, 32'hFFFF_FFFF, 0);
        do_op(2'b10, MIN_NEG, 32'hFFFF_FFFF, 0);

        // Squash mid-CALC: no result expected.
        @(negedge clk);
        start_i = 1'b1; op_i = 2'b01; op1_i = 32'd50; op2_i = 32'd6;
        repeat (10) @(negedge clk);
        squash_i = 1'b1;
        @(negedge clk);
        squash_i = 1'b0;
        start_i  = 1'b0;
        #1;
        check("squash_stall", {31'd0, stall_o}, 32'd0);
        seen_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done_o) seen_done = 1'b1;
        end
        check("squash_no_done", {31'd0, seen_done}, 32'd0);
        do_op(2'b01, 32'd9, 32'd3, 0);

        do_op(2'b00, 32'd1000, -32'sd33, 3);

        for (int i = 0; i < 30; i++) begin
            op = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 4))
                0: a = 32'd0;
                1: a = MIN_NEG;
                2: a = 32'hFFFF_FFFF;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: b = 32'($urandom_range(1, 20));
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            do_op(op, a, b, (i % 7 == 0) ? 2 : 0);
        end

        // Asynchronous reset during CALC.
        @(negedge clk);
        start_i = 1'b1; op_i = 2'b01; op1_i = 32'd77; op2_i = 32'd5;
        repeat (5) @(negedge clk);
        #2;
        rst_ni  = 1'b0;
        start_i = 1'b0;
        #1;
        check("reset_stall", {31'd0, stall_o}, 32'd0);
        check("reset_done", {31'd0, done_o}, 32'd0);
        check("reset_result", result_o, 32'd0);
        @(negedge clk);
        rst_ni = 1'b1;
        do_op(2'b01, 32'd9, 32'd3, 0);

        repeat (5) @(negedge clk);
        check("queue_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
